// File: rtl/uart_rx.sv
// uart_rx: UART receiver for 8 data bits (LSB first), 1 even-parity bit and 1 stop bit.
// Each bit is sampled at mid-bit. A completed frame, good or bad, is reported with a
// one-cycle valid strobe that is qualified by parity and framing error flags.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (8..65535)
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_serial   asynchronous serial input, idle high
//   rx_data     last received byte, held until the next rx_valid
//   rx_valid    one-cycle strobe when a frame completes
//   parity_err  parity error for the frame, qualified by rx_valid
//   frame_err   stop bit sampled low, qualified by rx_valid
//   rx_active   high while the receiver is not idle (registered, one cycle behind the FSM)
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_active
);

  localparam int unsigned Half   = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] HalfCnt = 16'(Half);
  localparam logic [15:0] BitEnd  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StData    = 3'd2,
    StParity  = 3'd3,
    StStop    = 3'd4,
    StCleanup = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_sync_q;
  logic [15:0] clk_count_q, clk_count_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_bad_q, par_bad_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_active_q, rx_active_d;

  // Two-flop synchronizer, reset to the idle line level so reset never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_count_d  = clk_count_q;
    bit_index_d  = bit_index_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    rx_active_d  = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        clk_count_d = '0;
        bit_index_d = '0;
        if (!rx_sync_q) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (clk_count_q == HalfCnt) begin
          clk_count_d = '0;
          // Line back high at mid start bit: a glitch, not a frame.
          state_d     = rx_sync_q ? StIdle : StData;
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end

      StData: begin
        if (clk_count_q == BitEnd) begin
          clk_count_d          = '0;
          shift_d[bit_index_q] = rx_sync_q;
          if (bit_index_q == 3'd7) begin
            bit_index_d = '0;
            state_d     = StParity;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end

      StParity: begin
        if (clk_count_q == BitEnd) begin
          clk_count_d = '0;
          par_bad_d   = rx_sync_q ^ (^shift_q);
          state_d     = StStop;
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end

      StStop: begin
        if (clk_count_q == BitEnd) begin
          clk_count_d  = '0;
          rx_data_d    = shift_q;
          rx_valid_d   = 1'b1;
          parity_err_d = par_bad_q;
          frame_err_d  = ~rx_sync_q;
          state_d      = StCleanup;
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end

      StCleanup: begin
        // Hold here while the line is low (break / low stop) so it cannot retrigger.
        if (rx_sync_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d     = StIdle;
        clk_count_d = '0;
        bit_index_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      clk_count_q  <= '0;
      bit_index_q  <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_active_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_count_q  <= clk_count_d;
      bit_index_q  <= bit_index_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_active_q  <= rx_active_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_active  = rx_active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT = 16 (HALF = 7).
module tb_uart_rx;

  localparam int unsigned Cpb  = 16;
  localparam int unsigned Half = 7;
  // Falling edge to rx_valid: (HALF+1) + 10*CPB + 3.
  localparam int Latency = 171;

  logic       clk;
  logic       rst_n;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_active;

  int n_checks = 0;
  int n_errors = 0;

  int cyc       = 0;
  int start_cyc = 0;
  int valid_cyc = 0;
  int act_low   = 0;
  bit wide_seen = 1'b0;
  bit stray     = 1'b0;
  bit prev_vld  = 1'b0;
  logic [9:0] rx_q[$];

  uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .rx_active (rx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every completed frame as {frame_err, parity_err, rx_data}.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_q.push_back({frame_err, parity_err, rx_data});
      valid_cyc = cyc;
      if (prev_vld) wide_seen = 1'b1;
    end else if (parity_err || frame_err) begin
      stray = 1'b1;
    end
    prev_vld = rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] fr;
    fr = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_serial = fr[i];
      if (i == 0) start_cyc = cyc;
      tick(Cpb / 2);
      if (!rx_active) act_low++;
      tick(Cpb / 2);
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    rx_serial = 1'b1;
    tick(3);
    n_checks++; if (rx_data !== 8'h00) begin n_errors++;
      $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_errors++;
      $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_checks++; if (parity_err !== 1'b0) begin n_errors++;
      $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    n_checks++; if (frame_err !== 1'b0) begin n_errors++;
      $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (rx_active !== 1'b0) begin n_errors++;
      $display("FAIL reset_rx_active: got %b expected 0", rx_active); end
    rst_n = 1'b1;
    tick(5);
    n_checks++; if (rx_active !== 1'b0 || rx_q.size() != 0) begin n_errors++;
      $display("FAIL idle_after_reset: active %b frames %0d expected 0 0", rx_active,
               rx_q.size()); end
  endtask

  task automatic test_good_frame;
    rx_q.delete();
    act_low   = 0;
    wide_seen = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1);
    tick(4);
    n_checks++; if (rx_q.size() != 1) begin n_errors++;
      $display("FAIL good_count: got %0d expected 1", rx_q.size()); end
    else begin
      n_checks++; if (rx_q[0] !== 10'h0A5) begin n_errors++;
        $display("FAIL good_frame: got %h expected 0a5", rx_q[0]); end
    end
    n_checks++; if (rx_data !== 8'hA5) begin n_errors++;
      $display("FAIL good_hold: got %h expected a5", rx_data); end
    n_checks++; if (wide_seen !== 1'b0) begin n_errors++;
      $display("FAIL strobe_width: got wide %b expected 0", wide_seen); end
    n_checks++; if (act_low != 0) begin n_errors++;
      $display("FAIL active_in_frame: got %0d low samples expected 0", act_low); end
    n_checks++;
    if (valid_cyc - start_cyc < Latency - 1 || valid_cyc - start_cyc > Latency + 1) begin
      n_errors++;
      $display("FAIL latency: got %0d expected %0d", valid_cyc - start_cyc, Latency);
    end
    n_checks++; if (rx_active !== 1'b0) begin n_errors++;
      $display("FAIL active_fall: got %b expected 0", rx_active); end
  endtask

  task automatic test_parity_err;
    rx_q.delete();
    send_frame(8'h01, 1'b0, 1'b1);
    tick(4);
    n_checks++; if (rx_q.size() != 1) begin n_errors++;
      $display("FAIL parity_count: got %0d expected 1", rx_q.size()); end
    else begin
      n_checks++; if (rx_q[0] !== 10'h101) begin n_errors++;
        $display("FAIL parity_frame: got %h expected 101", rx_q[0]); end
    end
  endtask

  task automatic test_frame_break;
    rx_q.delete();
    stray = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(40);
    n_checks++; if (rx_active !== 1'b1) begin n_errors++;
      $display("FAIL break_hold_active: got %b expected 1", rx_active); end
    rx_serial = 1'b1;
    tick(6);
    n_checks++; if (rx_active !== 1'b0) begin n_errors++;
      $display("FAIL break_release: got %b expected 0", rx_active); end
    n_checks++; if (rx_q.size() != 1) begin n_errors++;
      $display("FAIL break_count: got %0d expected 1", rx_q.size()); end
    else begin
      n_checks++; if (rx_q[0] !== 10'h23C) begin n_errors++;
        $display("FAIL break_frame: got %h expected 23c", rx_q[0]); end
    end
    n_checks++; if (stray !== 1'b0) begin n_errors++;
      $display("FAIL flags_unqualified: got %b expected 0", stray); end
  endtask

  task automatic test_false_start;
    rx_q.delete();
    rx_serial = 1'b0;
    tick(5);
    n_checks++; if (rx_active !== 1'b1) begin n_errors++;
      $display("FAIL false_start_active: got %b expected 1", rx_active); end
    rx_serial = 1'b1;
    tick(Half + 3);
    n_checks++; if (rx_active !== 1'b0) begin n_errors++;
      $display("FAIL false_start_idle: got %b expected 0", rx_active); end
    tick(Cpb * 12);
    n_checks++; if (rx_q.size() != 0) begin n_errors++;
      $display("FAIL false_start_valid: got %0d frames expected 0", rx_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes[10];
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    for (int i = 2; i < 10; i++) bytes[i] = 8'($urandom_range(0, 255));
    rx_q.delete();
    for (int i = 0; i < 10; i++) send_frame(bytes[i], ^bytes[i], 1'b1);
    tick(4);
    n_checks++; if (rx_q.size() != 10) begin n_errors++;
      $display("FAIL b2b_count: got %0d expected 10", rx_q.size()); end
    else begin
      for (int i = 0; i < 10; i++) begin
        n_checks++; if (rx_q[i] !== {2'b00, bytes[i]}) begin n_errors++;
          $display("FAIL b2b_frame%0d: got %h expected %h", i, rx_q[i], {2'b00, bytes[i]});
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] fr;
    fr = {1'b1, 1'b0, 8'h5A, 1'b0};
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      rx_serial = fr[i];
      tick(Cpb);
    end
    rx_serial = fr[5];
    tick(Cpb / 2);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({rx_data, rx_valid, parity_err, frame_err, rx_active} !== 12'h000) begin
      n_errors++;
      $display("FAIL mid_reset_outputs: got data %h v%b p%b f%b a%b expected all zero",
               rx_data, rx_valid, parity_err, frame_err, rx_active);
    end
    tick(3);
    rx_serial = 1'b1;
    rst_n     = 1'b1;
    tick(Cpb * 8);
    n_checks++; if (rx_q.size() != 0) begin n_errors++;
      $display("FAIL mid_reset_valid: got %0d frames expected 0", rx_q.size()); end
    send_frame(8'h77, 1'b0, 1'b1);
    tick(4);
    n_checks++; if (rx_q.size() != 1) begin n_errors++;
      $display("FAIL after_reset_count: got %0d expected 1", rx_q.size()); end
    else begin
      n_checks++; if (rx_q[0] !== 10'h077) begin n_errors++;
        $display("FAIL after_reset_frame: got %h expected 077", rx_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_break();
    test_false_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver paired with `uart_tx` on the same serial link. It deserializes frames of 1 start bit, 8 data bits sent LSB-first, 1 even-parity bit and 1 stop bit at `CLKS_PER_BIT` clocks per bit. It samples each bit at mid-bit and presents the byte with a one-cycle valid strobe, qualified by parity and framing error flags. It sits between the asynchronous `rx_serial` pin and the host-side byte consumer, and is looped back against `uart_tx` in the UVM bench.

## Interface
- `CLKS_PER_BIT`, 868, clocks per bit (115200 baud @ 100 MHz); legal range 8..65535.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_serial`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  8  last received byte; holds until the next `rx_valid`.
- `rx_valid`  out  1  one-cycle strobe when a frame completes, good or bad.
- `parity_err`  out  1  parity error for the frame; valid when `rx_valid`=1, else 0.
- `frame_err`  out  1  stop bit sampled low; valid when `rx_valid`=1, else 0.
- `rx_active`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Input synchronizer:** `rx_serial` passes through a 2-flop synchronizer to give `rx_sync`. Both flops reset to 1. All FSM decisions use `rx_sync` only.
- **Counters:** `clk_count` is 16 bits; `bit_index` is 3 bits. Define HALF = (CLKS_PER_BIT-1)/2, using integer division (433 at the default).
- **IDLE:** `clk_count`=0, `bit_index`=0. When `rx_sync`=0, go to START.
- **START:** increment `clk_count` until it reaches HALF, then re-sample `rx_sync`.
  - If `rx_sync`=0: clear `clk_count` and go to DATA.
  - If `rx_sync`=1 (glitch / false start): go to IDLE with no outputs asserted.
- **DATA:** count to CLKS_PER_BIT-1, then sample `rx_sync` into shift-register bit `bit_index` and clear `clk_count`.
  - After bit 7, reset `bit_index` to 0 and go to PARITY.
- **PARITY:** count to CLKS_PER_BIT-1, then sample the parity bit.
  - Parity error = sampled bit != XOR of the 8 data bits (even parity: total ones across data+parity is even).
- **STOP:** count to CLKS_PER_BIT-1, then sample the stop bit. In that same registered update:
  - load `rx_data` from the shift register;
  - pulse `rx_valid`=1;
  - drive `parity_err` with the parity result;
  - drive `frame_err` = ~stop sample.
  - Then go to CLEANUP.
- **CLEANUP:** `rx_valid`, `parity_err` and `frame_err` return to 0. Go to IDLE only when `rx_sync`=1; otherwise wait here.
  - This covers a break or a low stop bit, so a stuck-low line never re-triggers a start.
- **Error frames:** `rx_data` is still updated on an errored frame; the consumer discards it using the flags.
- **Illegal state:** any illegal state encoding returns to IDLE.

## Timing
- **Reset values:** `rx_data`=8'h00; `rx_valid`, `parity_err`, `frame_err` and `rx_active` are 0; FSM in IDLE; synchronizer flops at 1.
- **Reset mid-frame:** `rst_n` low at any point aborts the frame immediately (asynchronous). No `rx_valid` is produced for the partial frame.
- **Sample points:** the start bit is confirmed HALF+1 clocks after START entry. Each later bit is sampled CLKS_PER_BIT clocks after the previous sample, so all samples land at mid-bit.
- **Latency:** `rx_valid` rises (HALF+1) + 10×CLKS_PER_BIT + 3 clocks (±1) after the falling edge on `rx_serial`. The +3 covers the 2 synchronizer clocks plus the IDLE→START clock. At default this is 9117 clocks.
- **Strobe width:** `rx_valid` is exactly 1 cycle wide. There is no backpressure; the consumer must take `rx_data` on the strobe.
- **`rx_active` timing:** rises the cycle after START is entered and falls the cycle after the return to IDLE.
- **Back-to-back frames:** a new start bit immediately after a good stop bit is accepted. The stop sample sits at mid-bit, and CLEANUP+IDLE cost 2 clocks, leaving about HALF−2 clocks of margin. Tolerance is ±(HALF−3) clocks of bit-edge drift per frame.

## Test plan
- **Good frame (CLKS_PER_BIT=16, HALF=7):** drive 0xA5 with parity 0 and stop 1. Expect:
  - `rx_valid` for one cycle with `rx_data`=0xA5 and both error flags 0;
  - `rx_active` high throughout the frame.
- **Parity error:** send 0x01 with parity bit 0 (correct is 1) -> `rx_valid`=1, `rx_data`=0x01, `parity_err`=1, `frame_err`=0.
- **Framing error + break:** send 0x3C, then hold the stop bit and the line low for 40 clocks. Expect:
  - `rx_valid`=1 with `frame_err`=1 and `rx_data`=0x3C;
  - FSM stays in CLEANUP (`rx_active`=1) until the line rises;
  - no second `rx_valid`.
- **False start:** a low pulse of 5 clocks on an idle line -> no `rx_valid`; `rx_active` returns to 0 within HALF+3 clocks.
- **Back-to-back:** 0x00 then 0xFF with no idle gap -> two `rx_valid` strobes with the correct bytes and no errors. Loopback through `uart_tx` for 256 random bytes must match exactly.
- **Reset mid-frame:** assert `rst_n` low during data bit 4 of 0x5A, then release. Expect:
  - all outputs at their reset values;
  - no `rx_valid` for the aborted frame;
  - the next full frame 0x77 is received correctly.
